// File: rtl/branch_selector_pkg.sv
// Shared definitions for the EX-stage branch condition evaluator:
// operand width and the RISC-V branch funct3 encodings.
package branch_selector_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_selector_comparator.sv
// Operand comparator: equality, two's-complement less-than and unsigned less-than.
module branch_comparator
    import branch_selector_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    logic signed [WIDTH-1:0] data1_s;
    logic signed [WIDTH-1:0] data2_s;

    assign data1_s = data1;
    assign data2_s = data2;

    assign eq  = (data1 == data2);
    assign lt  = (data1_s < data2_s);
    assign ltu = (data1 < data2);

endmodule

// File: rtl/branch_selector.sv
// Branch decision from funct3 and the comparator flags; the decision is
// available combinationally for PC redirect and as a registered copy.
module branch_selector
    import branch_selector_pkg::*;
#(
    parameter int XLEN = branch_selector_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [2:0]      BRANCH_TYPE,
    output logic            BRANCH_TAKEN,
    output logic            BRANCH_TAKEN_Q,
    output logic            EQ_FLAG,
    output logic            LT_FLAG,
    output logic            LTU_FLAG
);

    logic eq;
    logic lt;
    logic ltu;

    branch_comparator #(
        .WIDTH (XLEN)
    ) u_comparator (
        .data1 (DATA1),
        .data2 (DATA2),
        .eq    (eq),
        .lt    (lt),
        .ltu   (ltu)
    );

    assign EQ_FLAG  = eq;
    assign LT_FLAG  = lt;
    assign LTU_FLAG = ltu;

    // Reserved encodings (010, 011) and unknown select values fall to never-taken.
    always_comb begin
        BRANCH_TAKEN = 1'b0;
        case (BRANCH_TYPE)
            F3_BEQ:  BRANCH_TAKEN = eq;
            F3_BNE:  BRANCH_TAKEN = ~eq;
            F3_BLT:  BRANCH_TAKEN = lt;
            F3_BGE:  BRANCH_TAKEN = ~lt;
            F3_BLTU: BRANCH_TAKEN = ltu;
            F3_BGEU: BRANCH_TAKEN = ~ltu;
            default: BRANCH_TAKEN = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BRANCH_TAKEN_Q <= 1'b0;
        end else begin
            BRANCH_TAKEN_Q <= BRANCH_TAKEN;
        end
    end

endmodule

// File: tb/tb_branch_selector.sv
// Self-checking bench for branch_selector: directed boundary cases, randomized
// operands against a behavioural model, and asynchronous reset behaviour.
module tb_branch_selector;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [2:0]  BRANCH_TYPE;
    logic        BRANCH_TAKEN;
    logic        BRANCH_TAKEN_Q;
    logic        EQ_FLAG;
    logic        LT_FLAG;
    logic        LTU_FLAG;

    int checks = 0;
    int errors = 0;
    logic exp_q = 1'b0;

    branch_selector dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .DATA1          (DATA1),
        .DATA2          (DATA2),
        .BRANCH_TYPE    (BRANCH_TYPE),
        .BRANCH_TAKEN   (BRANCH_TAKEN),
        .BRANCH_TAKEN_Q (BRANCH_TAKEN_Q),
        .EQ_FLAG        (EQ_FLAG),
        .LT_FLAG        (LT_FLAG),
        .LTU_FLAG       (LTU_FLAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (checks %0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (a=%08h b=%08h t=%03b)",
                     tag, got, exp, DATA1, DATA2, BRANCH_TYPE);
        end
    endtask

    // Behavioural reference: straight from the funct3 meaning of each branch.
    function automatic bit ref_lt(input bit [31:0] a, input bit [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        return sa < sb;
    endfunction

    function automatic bit ref_taken(input bit [31:0] a, input bit [31:0] b, input bit [2:0] t);
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return ref_lt(a, b);
            3'd5:    return !ref_lt(a, b);
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    // One cycle: check the register captured last cycle's decision, then apply
    // new operands and check the combinational outputs within the same cycle.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
        @(posedge CLK);
        #1;
        check("taken_q", {31'd0, BRANCH_TAKEN_Q}, {31'd0, exp_q});
        DATA1 = a;
        DATA2 = b;
        BRANCH_TYPE = t;
        #1;
        check("eq", {31'd0, EQ_FLAG}, {31'd0, a == b});
        check("lt", {31'd0, LT_FLAG}, {31'd0, ref_lt(a, b)});
        check("ltu", {31'd0, LTU_FLAG}, {31'd0, a < b});
        check("taken", {31'd0, BRANCH_TAKEN}, {31'd0, ref_taken(a, b, t)});
        exp_q = ref_taken(a, b, t);
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t,
                            input logic want);
        drive(a, b, t);
        check("directed", {31'd0, BRANCH_TAKEN}, {31'd0, want});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001;
        specials[5] = 32'h0000_0010;

        // Reset held with a taken branch on the inputs.
        RESET_N = 1'b0;
        DATA1 = 32'h5;
        DATA2 = 32'h5;
        BRANCH_TYPE = 3'b000;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_q", {31'd0, BRANCH_TAKEN_Q}, 32'd0);
        check("reset_taken", {31'd0, BRANCH_TAKEN}, 32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        exp_q = 1'b1;

        directed(32'h12345678, 32'h12345678, 3'b000, 1'b1);
        directed(32'h12345678, 32'h87654321, 3'b000, 1'b0);
        directed(32'h12345678, 32'h12345678, 3'b001, 1'b0);
        directed(32'h12345678, 32'h87654321, 3'b001, 1'b1);
        directed(32'hFFFFFFFF, 32'h00000000, 3'b001, 1'b1);
        directed(32'hFFFFFFF0, 32'h00000010, 3'b100, 1'b1);
        directed(32'h00000010, 32'hFFFFFFF0, 3'b100, 1'b0);
        directed(32'hFFFFFFE0, 32'hFFFFFFF0, 3'b100, 1'b1);
        directed(32'h00000010, 32'h00000010, 3'b100, 1'b0);
        directed(32'h00000010, 32'h00000010, 3'b101, 1'b1);
        directed(32'h00000010, 32'h00000020, 3'b101, 1'b0);
        directed(32'h00000010, 32'hFFFFFFF0, 3'b110, 1'b1);
        directed(32'hFFFFFFF0, 32'h00000010, 3'b110, 1'b0);
        directed(32'hFFFFFFF0, 32'h00000010, 3'b111, 1'b1);
        directed(32'h00000010, 32'hFFFFFFF0, 3'b111, 1'b0);
        directed(32'h00000010, 32'h00000010, 3'b110, 1'b0);
        directed(32'h00000010, 32'h00000010, 3'b111, 1'b1);
        directed(32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1);
        directed(32'h80000000, 32'h7FFFFFFF, 3'b110, 1'b0);
        directed(32'h00000010, 32'h00000010, 3'b010, 1'b0);
        directed(32'h00000001, 32'h00000020, 3'b011, 1'b0);
        directed(32'hFFFFFFFF, 32'h00000000, 3'b010, 1'b0);

        // Randomized: mix of arbitrary, equal and corner-value operands.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: a = specials[$urandom_range(0, 5)];
                2: begin
                    a = specials[$urandom_range(0, 5)];
                    b = specials[$urandom_range(0, 5)];
                end
                default: ;
            endcase
            drive(a, b, 3'($urandom_range(0, 7)));
        end

        // Reset asserted between edges while the registered copy is 1.
        drive(32'h7, 32'h7, 3'b000);
        @(posedge CLK);
        #1;
        check("pre_async_q", {31'd0, BRANCH_TAKEN_Q}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_q", {31'd0, BRANCH_TAKEN_Q}, 32'd0);
        check("async_taken", {31'd0, BRANCH_TAKEN}, 32'd1);
        DATA2 = 32'h8;
        #1;
        check("async_comb", {31'd0, BRANCH_TAKEN}, 32'd0);
        DATA2 = 32'h7;
        @(posedge CLK);
        #1;
        check("held_q", {31'd0, BRANCH_TAKEN_Q}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        exp_q = 1'b1;
        drive(32'h1, 32'h2, 3'b110);
        drive(32'h1, 32'h2, 3'b111);
        drive(32'h1, 32'h2, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
